debug_slave_jtag_host: RTL and testbench

- Drives the 2-bit-IR / 38-bit-DR virtual-JTAG interface of the Nios II debug slave from the system clock. It acts as the host/initiator end, taking the place of the sld_virtual_jtag_basic hub in simulation and in standalone test harnesses.
- Accepts a command (IR value plus DR payload), generates tck, the virtual-state strobes and serial tdi, captures tdo and ir_out, and returns the captured DR.
- Lets the debug slave's tck and sysclk logic be exercised without a physical JTAG cable.

---
 rtl/debug_slave_jtag_host_if.sv | 36 +++
 rtl/debug_slave_jtag_host.sv | 224 ++++++++++++++++++++++
 tb/tb_debug_slave_jtag_host.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_slave_jtag_host_if.sv
// Command/response bus and virtual-JTAG pins between the JTAG host engine and its user.
// The slave modport is the host engine's view; master is the command issuer / debug-slave side.
interface debug_slave_jtag_host_if #(
    parameter int unsigned IR_W = 2,
    parameter int unsigned DR_W = 38
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir;
    logic            vji_tck;
    logic            vji_tdi;
    logic            vji_tdo;
    logic [IR_W-1:0] vji_ir_in;
    logic [IR_W-1:0] vji_ir_out;
    logic            vji_uir;
    logic            vji_cdr;
    logic            vji_sdr;
    logic            vji_udr;
    logic            vji_rti;

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir,
        output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir,
        input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/debug_slave_jtag_host.sv
// Virtual-JTAG host: turns one IR+DR command into a UIR/CDR/SDR/UDR/RTI sequence on a
// clk-derived tck and returns the captured DR and IR status.
module debug_slave_jtag_host #(
    parameter int unsigned IR_W       = 2,
    parameter int unsigned DR_W       = 38,
    parameter int unsigned TCK_HALF   = 2,
    parameter int unsigned RTI_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    debug_slave_jtag_host_if.slave bus
);
    localparam int unsigned HC_W = (TCK_HALF > 1)   ? $clog2(TCK_HALF)   : 1;
    localparam int unsigned SC_W = (DR_W > 1)       ? $clog2(DR_W)       : 1;
    localparam int unsigned RC_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(TCK_HALF - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(DR_W - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RTI_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
    } state_t;

    state_t          r_state,     w_state_nxt;
    logic [HC_W-1:0] r_half,      w_half_nxt;
    logic            r_tck,       w_tck_nxt;
    logic [SC_W-1:0] r_shift,     w_shift_nxt;
    logic [RC_W-1:0] r_rti_cnt,   w_rti_cnt_nxt;
    logic [DR_W-1:0] r_dr,        w_dr_nxt;
    logic [DR_W-1:0] r_cap,       w_cap_nxt;
    logic [IR_W-1:0] r_ir_cap,    w_ir_cap_nxt;
    logic [IR_W-1:0] r_ir_in,     w_ir_in_nxt;
    logic            r_tdi,       w_tdi_nxt;
    logic            r_uir,       w_uir_nxt;
    logic            r_cdr,       w_cdr_nxt;
    logic            r_sdr,       w_sdr_nxt;
    logic            r_udr,       w_udr_nxt;
    logic            r_rti,       w_rti_nxt;
    logic            r_cmd_ready, w_cmd_ready_nxt;
    logic            r_rsp_valid, w_rsp_valid_nxt;
    logic [DR_W-1:0] r_rsp_dr,    w_rsp_dr_nxt;
    logic [IR_W-1:0] r_rsp_ir,    w_rsp_ir_nxt;

    logic            w_busy;
    logic            w_tick;
    logic            w_rise;
    logic            w_fall;

    // State and every output are registered together so outputs never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_half      <= '0;
            r_tck       <= 1'b0;
            r_shift     <= '0;
            r_rti_cnt   <= '0;
            r_dr        <= '0;
            r_cap       <= '0;
            r_ir_cap    <= '0;
            r_ir_in     <= '0;
            r_tdi       <= 1'b0;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
            r_rti       <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dr    <= '0;
            r_rsp_ir    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_half      <= w_half_nxt;
            r_tck       <= w_tck_nxt;
            r_shift     <= w_shift_nxt;
            r_rti_cnt   <= w_rti_cnt_nxt;
            r_dr        <= w_dr_nxt;
            r_cap       <= w_cap_nxt;
            r_ir_cap    <= w_ir_cap_nxt;
            r_ir_in     <= w_ir_in_nxt;
            r_tdi       <= w_tdi_nxt;
            r_uir       <= w_uir_nxt;
            r_cdr       <= w_cdr_nxt;
            r_sdr       <= w_sdr_nxt;
            r_udr       <= w_udr_nxt;
            r_rti       <= w_rti_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dr    <= w_rsp_dr_nxt;
            r_rsp_ir    <= w_rsp_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_half_nxt      = r_half;
        w_tck_nxt       = r_tck;
        w_shift_nxt     = r_shift;
        w_rti_cnt_nxt   = r_rti_cnt;
        w_dr_nxt        = r_dr;
        w_cap_nxt       = r_cap;
        w_ir_cap_nxt    = r_ir_cap;
        w_ir_in_nxt     = r_ir_in;
        w_tdi_nxt       = r_tdi;
        w_uir_nxt       = r_uir;
        w_cdr_nxt       = r_cdr;
        w_sdr_nxt       = r_sdr;
        w_udr_nxt       = r_udr;
        w_rti_nxt       = r_rti;
        w_cmd_ready_nxt = r_cmd_ready;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_dr_nxt    = r_rsp_dr;
        w_rsp_ir_nxt    = r_rsp_ir;

        // tck only runs in the timed states; a falling tck marks the next period start.
        w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
        w_tick = (r_half == HC_LAST);
        w_rise = 1'b0;
        w_fall = 1'b0;
        if (w_busy) begin
            if (w_tick) begin
                w_half_nxt = '0;
                w_tck_nxt  = ~r_tck;
                w_rise     = ~r_tck;
                w_fall     = r_tck;
            end else begin
                w_half_nxt = r_half + HC_W'(1);
            end
        end

        // Slave outputs are sampled on the clk edge that raises tck.
        if (w_rise) begin
            if (r_state == S_UIR) w_ir_cap_nxt = bus.vji_ir_out;
            if (r_state == S_SDR) w_cap_nxt    = {bus.vji_tdo, r_cap[DR_W-1:1]};
        end

        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state_nxt     = S_UIR;
                    w_cmd_ready_nxt = 1'b0;
                    w_dr_nxt        = bus.cmd_dr;
                    w_ir_in_nxt     = bus.cmd_ir;
                    w_uir_nxt       = 1'b1;
                    w_rti_nxt       = 1'b0;
                    w_tdi_nxt       = 1'b0;
                    w_half_nxt      = '0;
                    w_tck_nxt       = 1'b0;
                end
            end
            S_UIR: begin
                if (w_fall) begin
                    w_state_nxt = S_CDR;
                    w_uir_nxt   = 1'b0;
                    w_cdr_nxt   = 1'b1;
                end
            end
            S_CDR: begin
                if (w_fall) begin
                    w_state_nxt = S_SDR;
                    w_cdr_nxt   = 1'b0;
                    w_sdr_nxt   = 1'b1;
                    w_shift_nxt = '0;
                    w_tdi_nxt   = r_dr[0];
                end
            end
            S_SDR: begin
                if (w_fall) begin
                    if (r_shift == SC_LAST) begin
                        w_state_nxt = S_UDR;
                        w_sdr_nxt   = 1'b0;
                        w_udr_nxt   = 1'b1;
                        w_tdi_nxt   = 1'b0;
                    end else begin
                        w_shift_nxt = r_shift + SC_W'(1);
                        w_dr_nxt    = r_dr >> 1;
                        w_tdi_nxt   = r_dr[1];
                    end
                end
            end
            S_UDR: begin
                if (w_fall) begin
                    w_state_nxt   = S_RTI;
                    w_udr_nxt     = 1'b0;
                    w_rti_nxt     = 1'b1;
                    w_rti_cnt_nxt = '0;
                end
            end
            S_RTI: begin
                if (w_fall) begin
                    if (r_rti_cnt == RC_LAST) begin
                        w_state_nxt     = S_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_dr_nxt    = r_cap;
                        w_rsp_ir_nxt    = r_ir_cap;
                    end else begin
                        w_rti_cnt_nxt = r_rti_cnt + RC_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_cmd_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_dr    = r_rsp_dr;
    assign bus.rsp_ir    = r_rsp_ir;
    assign bus.vji_tck   = r_tck;
    assign bus.vji_tdi   = r_tdi;
    assign bus.vji_ir_in = r_ir_in;
    assign bus.vji_uir   = r_uir;
    assign bus.vji_cdr   = r_cdr;
    assign bus.vji_sdr   = r_sdr;
    assign bus.vji_udr   = r_udr;
    assign bus.vji_rti   = r_rti;
endmodule

// File: tb/tb_debug_slave_jtag_host.sv
// Scoreboard bench: two hosts (default timing and TCK_HALF=1/RTI_CYCLES=1) driven with random
// commands; expected waveforms and responses come from a period-index model of the sequence.
module tb_debug_slave_jtag_host;
    localparam int unsigned IR_W = 2;
    localparam int unsigned DR_W = 38;
    localparam int TH0  = 2;
    localparam int RTI0 = 2;
    localparam int PER0 = 2 * TH0;
    localparam int L0   = (3 + DR_W + RTI0) * PER0;
    localparam int TH1  = 1;
    localparam int RTI1 = 1;
    localparam int L1   = (3 + DR_W + RTI1) * 2 * TH1;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
        logic [DR_W-1:0] exp_dr;
        logic [IR_W-1:0] exp_ir;
        int              acc;
    } txn_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    debug_slave_jtag_host_if #(.IR_W(IR_W), .DR_W(DR_W)) bus0 ();
    debug_slave_jtag_host_if #(.IR_W(IR_W), .DR_W(DR_W)) bus1 ();

    debug_slave_jtag_host #(.IR_W(IR_W), .DR_W(DR_W), .TCK_HALF(TH0), .RTI_CYCLES(RTI0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    debug_slave_jtag_host #(.IR_W(IR_W), .DR_W(DR_W), .TCK_HALF(TH1), .RTI_CYCLES(RTI1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    // Slave stand-ins: 0 = loopback, 1 = constant one, 2 = inverted loopback.
    int              mode0 = 0;
    logic [IR_W-1:0] irout0 = '0;
    logic [IR_W-1:0] irout1 = '0;
    assign bus0.vji_tdo    = (mode0 == 0) ? bus0.vji_tdi : (mode0 == 1) ? 1'b1 : ~bus0.vji_tdi;
    assign bus0.vji_ir_out = irout0;
    assign bus1.vji_tdo    = bus1.vji_tdi;
    assign bus1.vji_ir_out = irout1;

    txn_t q0[$];
    txn_t q1[$];
    int   wave_err0 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DR_W-1:0] rnd_dr();
        return DR_W'({$urandom(), $urandom()});
    endfunction

    task automatic send0(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr, input int m,
                         input logic [IR_W-1:0] iro);
        txn_t t;
        int   n = 0;
        @(negedge clk);
        while (bus0.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait0", 64'(bus0.cmd_ready), 64'(1));
        mode0         = m;
        irout0        = iro;
        bus0.cmd_valid = 1'b1;
        bus0.cmd_ir    = ir;
        bus0.cmd_dr    = dr;
        t.ir     = ir;
        t.dr     = dr;
        t.exp_dr = (m == 0) ? dr : (m == 1) ? {DR_W{1'b1}} : ~dr;
        t.exp_ir = iro;
        t.acc    = cyc + 1;
        q0.push_back(t);
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        bus0.cmd_ir    = ~ir;
        bus0.cmd_dr    = rnd_dr();
    endtask

    task automatic send1(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr,
                         input logic [IR_W-1:0] iro);
        txn_t t;
        int   n = 0;
        @(negedge clk);
        while (bus1.cmd_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait1", 64'(bus1.cmd_ready), 64'(1));
        irout1         = iro;
        bus1.cmd_valid = 1'b1;
        bus1.cmd_ir    = ir;
        bus1.cmd_dr    = dr;
        t.ir     = ir;
        t.dr     = dr;
        t.exp_dr = dr;
        t.exp_ir = iro;
        t.acc    = cyc + 1;
        q1.push_back(t);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        bus1.cmd_dr    = rnd_dr();
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_ctl"}, 64'({bus0.cmd_ready, bus0.rsp_valid, bus0.vji_tck, bus0.vji_tdi,
                                 bus0.vji_uir, bus0.vji_cdr, bus0.vji_sdr, bus0.vji_udr, bus0.vji_rti}),
            64'(9'b1_0000_0000 | 9'b1));
        chk({name, "_rsp_dr"}, 64'(bus0.rsp_dr), 64'(0));
        chk({name, "_ir"}, 64'({bus0.rsp_ir, bus0.vji_ir_in}), 64'(0));
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk((which == 0) ? "drain0" : "drain1", 64'((which == 0) ? q0.size() : q1.size()), 64'(0));
    endtask

    // Reference waveform for dut0: everything follows from the period index since accept.
    initial begin : mon0
        int   t, p, ph;
        logic act, e_ready, e_rv, e_tck, e_tdi, prev_rsp;
        logic [4:0]      e_str;
        logic [IR_W-1:0] cur_ir;
        logic [10:0]     exp_v, act_v;
        txn_t            tx;
        prev_rsp = 1'b0;
        cur_ir   = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                q0.delete();
                cur_ir   = '0;
                prev_rsp = 1'b0;
            end else begin
                act = 1'b0;
                t   = 0;
                if (q0.size() > 0) begin
                    t   = cyc - q0[0].acc;
                    act = (t >= 0);
                end
                e_ready = 1'b1; e_rv = 1'b0; e_tck = 1'b0; e_str = 5'b00001; e_tdi = 1'b0;
                if (act) begin
                    if (t == 0) cur_ir = q0[0].ir;
                    e_ready = 1'b0;
                    if (t < L0) begin
                        p     = t / PER0;
                        ph    = t % PER0;
                        e_tck = (ph >= TH0);
                        if (p == 0)                e_str = 5'b10000;
                        else if (p == 1)           e_str = 5'b01000;
                        else if (p < 2 + DR_W)     e_str = 5'b00100;
                        else if (p == 2 + DR_W)    e_str = 5'b00010;
                        else                       e_str = 5'b00001;
                        if (p >= 2 && p < 2 + DR_W) e_tdi = q0[0].dr[p-2];
                    end else begin
                        e_rv = (t == L0);
                    end
                end
                exp_v = {e_ready, e_rv, e_tck, e_str, e_tdi, cur_ir};
                act_v = {bus0.cmd_ready, bus0.rsp_valid, bus0.vji_tck, bus0.vji_uir, bus0.vji_cdr,
                         bus0.vji_sdr, bus0.vji_udr, bus0.vji_rti, bus0.vji_tdi, bus0.vji_ir_in};
                if (act_v !== exp_v) begin
                    wave_err0++;
                    if (wave_err0 <= 4)
                        $display("wave diff cycle %0d t=%0d got %b want %b", cyc, t, act_v, exp_v);
                end
                if (prev_rsp) chk("ready_after_done", 64'(bus0.cmd_ready), 64'(1));
                if (bus0.rsp_valid) begin
                    chk("rsp_expected0", 64'(q0.size() > 0), 64'(1));
                    if (q0.size() > 0) begin
                        tx = q0.pop_front();
                        chk("rsp_dr0", 64'(bus0.rsp_dr), 64'(tx.exp_dr));
                        chk("rsp_ir0", 64'(bus0.rsp_ir), 64'(tx.exp_ir));
                        chk("latency0", 64'(cyc - tx.acc), 64'(L0));
                        chk("waveform0", 64'(wave_err0), 64'(0));
                        wave_err0 = 0;
                    end
                end
                prev_rsp = bus0.rsp_valid;
            end
        end
    end

    initial begin : mon1
        txn_t tx;
        forever begin
            @(negedge clk);
            if (!reset_n) q1.delete();
            else if (bus1.rsp_valid) begin
                chk("rsp_expected1", 64'(q1.size() > 0), 64'(1));
                if (q1.size() > 0) begin
                    tx = q1.pop_front();
                    chk("rsp_dr1", 64'(bus1.rsp_dr), 64'(tx.exp_dr));
                    chk("rsp_ir1", 64'(bus1.rsp_ir), 64'(tx.exp_ir));
                    chk("latency1", 64'(cyc - tx.acc), 64'(L1));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DR_W-1:0] d;
        bus0.cmd_valid = 1'b0; bus0.cmd_ir = '0; bus0.cmd_dr = '0;
        bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_init");
        reset_n = 1'b1;

        // Loopback with the reference payload.
        send0(2'b01, 38'h2A_5A5A_5A5A, 0, 2'b00);
        // Constant-one tdo with a fixed IR status.
        send0(2'b11, rnd_dr(), 1, 2'b10);

        // A second request during SDR must be ignored; the next command follows back-to-back.
        send0(2'b10, rnd_dr(), 2, 2'b01);
        repeat (60) @(negedge clk);
        bus0.cmd_valid = 1'b1;
        bus0.cmd_ir    = 2'b11;
        bus0.cmd_dr    = rnd_dr();
        repeat (20) @(negedge clk);
        bus0.cmd_valid = 1'b0;
        send0(2'b01, rnd_dr(), 0, 2'b11);

        for (int i = 0; i < 10; i++)
            send0(IR_W'($urandom_range(0, 3)), rnd_dr(), int'($urandom_range(0, 2)),
                  IR_W'($urandom_range(0, 3)));
        drain(0);

        // Reset in shift period 10 discards the transaction.
        d = rnd_dr();
        send0(2'b10, d, 0, 2'b01);
        repeat ((2 + 10) * PER0) @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_vals("reset_mid");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        send0(2'b01, rnd_dr(), 0, 2'b10);
        drain(0);
        chk("idle_waveform0", 64'(wave_err0), 64'(0));

        // Fast timing variant.
        send1(2'b01, 38'h2A_5A5A_5A5A, 2'b10);
        for (int i = 0; i < 4; i++)
            send1(IR_W'($urandom_range(0, 3)), rnd_dr(), IR_W'($urandom_range(0, 3)));
        drain(1);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
